// File: rtl/rr_encode_arbiter_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package rr_encode_arbiter_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // OR-reduction 8:3 encoder; exact for one-hot input, 0 for all-zero.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_encode_arbiter_pick8.sv
// Combinational rotate-and-find-first: first set req bit at or after ptr, wrapping mod 8.
module rr_pick8
    import rr_encode_arbiter_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner_c,
    output logic [IDX_W-1:0] winner_idx_c,
    output logic             any_req_c
);

    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;

    // rotated[i] is the request i positions after ptr; index math wraps in IDX_W bits
    always_comb begin
        rotated = '0;
        for (int i = 0; i < N; i++) begin
            rotated[i] = req[ptr + IDX_W'(i)];
        end
    end

    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    assign any_req_c    = |req;
    assign winner_c     = any_req_c ? idx_to_onehot(ptr + offset) : '0;
    assign winner_idx_c = onehot_to_idx(winner_c);

endmodule

// File: rtl/rr_encode_arbiter.sv
// 8-requester round-robin arbiter with registered one-hot grant and encoded index.
// Optional owner preemption after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_encode_arbiter
    import rr_encode_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic [CNT_W-1:0] busy_cnt
);

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [N-1:0]     req_masked;
    logic [N-1:0]     win_c;
    logic [IDX_W-1:0] win_idx_c;
    logic             any_c;
    logic             owner_req;
    logic             preempt;

    // The current owner never competes against itself; in IDLE grant is zero.
    assign req_masked = req & ~grant;
    assign owner_req  = |(req & grant);

    assign preempt = TIMEOUT_EN && (busy_cnt >= CNT_W'(MAX_HOLD)) && any_c;

    rr_pick8 u_pick (
        .req          (req_masked),
        .ptr          (ptr),
        .winner_c     (win_c),
        .winner_idx_c (win_idx_c),
        .any_req_c    (any_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            busy_cnt    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_c) begin
                        state       <= ARB_GRANT;
                        ptr         <= win_idx_c + IDX_W'(1);
                        grant       <= win_c;
                        grant_idx   <= win_idx_c;
                        grant_valid <= 1'b1;
                        busy_cnt    <= CNT_W'(1);
                    end
                end
                ARB_GRANT: begin
                    if (owner_req && !preempt) begin
                        if (busy_cnt != '1) begin
                            busy_cnt <= busy_cnt + CNT_W'(1);
                        end
                    end else if (any_c) begin
                        // hand over on the release edge, no bubble cycle
                        ptr         <= win_idx_c + IDX_W'(1);
                        grant       <= win_c;
                        grant_idx   <= win_idx_c;
                        grant_valid <= 1'b1;
                        busy_cnt    <= CNT_W'(1);
                    end else begin
                        state       <= ARB_IDLE;
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                        busy_cnt    <= '0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_encode_arbiter.sv
// Scoreboard bench for rr_encode_arbiter: stimulus queues expected outputs, a monitor compares.
module tb_rr_encode_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_MAX_HOLD = 4;
`else
    localparam int unsigned TB_MAX_HOLD = 16;
`endif

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic [7:0] busy_cnt;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    rr_encode_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .busy_cnt    (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] idx_of(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] g,
                        input logic [7:0] b);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        e.g = g;
        e.b = b;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle once stimulus has queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", int'(grant), int'(e.g));
                check("grant_idx", int'(grant_idx), int'(idx_of(e.g)));
                check("grant_valid", int'(grant_valid), int'(e.g != 8'h00));
                check("busy_cnt", int'(busy_cnt), int'(e.b));
                check("onehot0", int'($onehot0(grant)), 1);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 8'h00;

        // reset, single request, release
        step(1, 8'h00, 8'h00, 0);
        step(0, 8'h04, 8'h04, 1);
        step(0, 8'h04, 8'h04, 2);
        step(0, 8'h00, 8'h00, 0);

        // lone requester drops for one cycle, then is re-granted
        step(0, 8'h01, 8'h01, 1);
        step(0, 8'h00, 8'h00, 0);
        step(0, 8'h01, 8'h01, 1);
        step(0, 8'h00, 8'h00, 0);

        // rotation 0..7,0 from ptr=0, each owner releases after two cycles
        step(1, 8'h00, 8'h00, 0);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] drop;
            logic [7:0] own;
            drop = 8'h01 << ((k + 7) % 8);
            own  = 8'h01 << (k % 8);
            step(0, (k == 0) ? 8'hFF : (8'hFF & ~drop), own, 1);
            step(0, 8'hFF, own, 2);
        end
        step(0, 8'h00, 8'h00, 0);

        // wrap: grant 6 sets ptr=7, then 7 wins over 0, then 0
        step(0, 8'h40, 8'h40, 1);
        step(0, 8'h81, 8'h80, 1);
        step(0, 8'h01, 8'h01, 1);
        step(0, 8'h00, 8'h00, 0);

`ifndef ARB_TIMEOUT_EN
        // non-owner noise on req[5] while idx 3 holds
        step(0, 8'h08, 8'h08, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, (i % 2 == 0) ? 8'h28 : 8'h08, 8'h08, 8'(i + 2));
        end
        step(0, 8'h00, 8'h00, 0);
`endif

        // reset mid-grant, then arbitration restarts from ptr=0
        step(0, 8'h20, 8'h20, 1);
        for (int i = 2; i <= 7; i++) begin
            step(0, 8'h20, 8'h20, 8'(i));
        end
        step(1, 8'h20, 8'h00, 0);
        step(0, 8'h60, 8'h20, 1);
        step(0, 8'h40, 8'h40, 1);
        step(0, 8'h00, 8'h00, 0);

        // busy_cnt saturates at 255
        step(0, 8'h01, 8'h01, 1);
        for (int i = 2; i <= 260; i++) begin
            step(0, 8'h01, 8'h01, (i > 255) ? 8'd255 : 8'(i));
        end
        step(0, 8'h00, 8'h00, 0);

        // hold-limit behaviour with two contenders
        step(1, 8'h00, 8'h00, 0);
        step(0, 8'h03, 8'h01, 1);
        step(0, 8'h03, 8'h01, 2);
        step(0, 8'h03, 8'h01, 3);
        step(0, 8'h03, 8'h01, 4);
`ifdef ARB_TIMEOUT_EN
        step(0, 8'h03, 8'h02, 1);
        step(0, 8'h03, 8'h02, 2);
        step(0, 8'h03, 8'h02, 3);
        step(0, 8'h03, 8'h02, 4);
        step(0, 8'h03, 8'h01, 1);
        for (int i = 2; i <= 6; i++) begin
            step(0, 8'h01, 8'h01, 8'(i));
        end
`else
        for (int i = 5; i <= 8; i++) begin
            step(0, 8'h03, 8'h01, 8'(i));
        end
`endif
        step(0, 8'h00, 8'h00, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
